temp_range_ctrl: RTL and testbench
==================================

// Module: temp_range_ctrl
// PURPOSE
//  Command sequencer for the 4-bit temperature range register (up/down/load/reset-to-0 counter).
//  Turns three level push-button inputs into single-cycle up/down/load command pulses.
//  Adds press-and-hold auto-repeat, load > up > down priority, a conflict lockout and
//  saturation at MIN_VAL/MAX_VAL so the register never wraps.
//  Sits between the button synchronizer/debouncer and the range register.
// PARAMETERS
//  W           4     width of the temperature value
//  MAX_VAL     15    upper limit; cmd_up never issued when cur_temp==MAX_VAL
//  MIN_VAL     0     lower limit; cmd_down never issued when cur_temp==MIN_VAL
//  HOLD_CYC    1000  cycles from first pulse to first auto-repeat pulse (>=2)
//  REPEAT_CYC  250   cycles between auto-repeat pulses (>=2)
// PORTS
//  clk       in   1  clock
//  rst       in   1  reset, synchronous, active-high
//  btn_up    in   1  level, synchronized/debounced, active-high
//  btn_down  in   1  level, synchronized/debounced, active-high
//  btn_load  in   1  level, synchronized/debounced, active-high
//  cur_temp  in   W  current value fed back from the range register
//  cmd_up    out  1  1-cycle increment pulse to the range register
//  cmd_down  out  1  1-cycle decrement pulse to the range register
//  cmd_load  out  1  1-cycle load pulse to the range register
//  busy      out  1  high whenever state != IDLE
//  at_max    out  1  combinational: cur_temp==MAX_VAL
//  at_min    out  1  combinational: cur_temp==MIN_VAL
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, cmd_up/cmd_down/cmd_load=0, busy=0. Reset wins over all inputs and aborts any state.
//  - All cmd_* are registered. At most one is high in any cycle. None is ever high for 2 consecutive cycles.
//  - States: IDLE, HOLD, REPEAT, WAIT_REL.
//  - IDLE, evaluated at each clock edge:
//      btn_load=1                 -> cmd_load=1 next cycle; go to WAIT_REL. No repeat for load.
//      btn_up & btn_down, no load -> no command; go to WAIT_REL.
//      btn_up only                -> cmd_up=1 next cycle unless at_max; go to HOLD, counter=0, dir=up.
//      btn_down only              -> same as btn_up only, mirrored: dir=down, suppressed if at_min.
//      no button                  -> stay in IDLE.
//  - HOLD: counter increments each cycle while only the dir button is held.
//      On counter==HOLD_CYC-1: pulse dir (unless saturated); go to REPEAT, counter=0.
//      Net effect: first repeat pulse comes HOLD_CYC cycles after the initial pulse.
//  - REPEAT: pulse dir every REPEAT_CYC cycles while held. Saturated pulses are suppressed,
//      but the state is kept so a held button resumes if cur_temp moves away from the limit.
//  - HOLD/REPEAT exits:
//      dir button released, no other button -> IDLE the same edge.
//      any other button asserted             -> WAIT_REL, no command.
//  - WAIT_REL: stay until all three buttons are 0, then IDLE. No commands are issued in this state.
//  - Saturation check uses cur_temp sampled on the same edge that would register the pulse.
//      The register updates one cycle after the pulse; HOLD_CYC/REPEAT_CYC >= 2 guarantee fresh feedback.
//  - Counter width: $clog2(max(HOLD_CYC,REPEAT_CYC)). No wrap; cleared on every state change.
//  - Outputs never depend on cur_temp values outside [MIN_VAL,MAX_VAL]. Such values still block only the matching limit.
// TESTING (bench params HOLD_CYC=4, REPEAT_CYC=3, W=4)
//  1. rst=1 for 2 cycles with all buttons high -> all cmd_* = 0, busy=0. After release: WAIT_REL until buttons drop, no pulse.
//  2. cur_temp=5, btn_up high 1 cycle -> exactly one cmd_up, 1 cycle after the press edge. busy drops after release.
//  3. cur_temp=5, btn_up held 12 cycles -> cmd_up at t=1, 5, 8, 11 (initial, +HOLD, +REPEAT, +REPEAT). Nothing after release.
//  4. cur_temp=14 tracking the register, btn_up held -> pulses until cur_temp=15, then none; at_max=1. Same for down at MIN_VAL=0.
//  5. btn_up & btn_down together -> no command; busy=1 until both released. btn_load with btn_up -> single cmd_load only.
//  6. btn_down held in REPEAT, btn_load asserted -> no further cmd, WAIT_REL. Then rst mid-HOLD -> IDLE, no pending pulse.

Source files
------------

// File: rtl/temp_range_ctrl.sv
// temp_range_ctrl
//   Turns the three debounced push-button levels into single-cycle command
//   pulses for the 4-bit temperature range register. It provides press-and-hold
//   auto-repeat and a load > up > down priority. Any button conflict locks the
//   sequencer out until every button is released. Pulses are suppressed at
//   MIN_VAL/MAX_VAL, so the register never wraps.
//
//   Ports
//     clk, rst             clock; synchronous active-high reset
//     btn_up/down/load     synchronized, debounced button levels
//     cur_temp [W]         value fed back from the range register
//     cmd_up/down/load     registered 1-cycle command pulses
//     busy                 high whenever the sequencer is not idle
//     at_max / at_min      combinational limit flags on cur_temp
module temp_range_ctrl #(
  parameter int W          = 4,
  parameter int MAX_VAL    = 15,
  parameter int MIN_VAL    = 0,
  parameter int HOLD_CYC   = 1000,
  parameter int REPEAT_CYC = 250
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_load,
  input  logic [W-1:0] cur_temp,
  output logic         cmd_up,
  output logic         cmd_down,
  output logic         cmd_load,
  output logic         busy,
  output logic         at_max,
  output logic         at_min
);

  localparam int CNT_TOP = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CW      = (CNT_TOP > 2) ? $clog2(CNT_TOP) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);
  localparam logic [W-1:0]  MAX_L     = W'(MAX_VAL);
  localparam logic [W-1:0]  MIN_L     = W'(MIN_VAL);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_REL} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          dir_up, dir_up_nxt;
  logic          req_up, req_down, req_load;
  logic          cmd_up_nxt, cmd_down_nxt, cmd_load_nxt;
  logic          dir_btn, other_btn;

  // State register and registered command pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dir_up   <= 1'b0;
      cmd_up   <= 1'b0;
      cmd_down <= 1'b0;
      cmd_load <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dir_up   <= dir_up_nxt;
      cmd_up   <= cmd_up_nxt;
      cmd_down <= cmd_down_nxt;
      cmd_load <= cmd_load_nxt;
    end
  end

  // Next-state logic. It raises raw pulse requests, which are saturation-gated later.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dir_up_nxt = dir_up;
    req_up     = 1'b0;
    req_down   = 1'b0;
    req_load   = 1'b0;
    dir_btn    = dir_up ? btn_up : btn_down;
    other_btn  = btn_load | (dir_up ? btn_down : btn_up);

    unique case (state)
      IDLE: begin
        if (btn_load) begin
          req_load  = 1'b1;
          state_nxt = WAIT_REL;
        end else if (btn_up && btn_down) begin
          state_nxt = WAIT_REL;
        end else if (btn_up) begin
          req_up     = 1'b1;
          dir_up_nxt = 1'b1;
          state_nxt  = HOLD;
        end else if (btn_down) begin
          req_down   = 1'b1;
          dir_up_nxt = 1'b0;
          state_nxt  = HOLD;
        end
      end
      HOLD, REPEAT: begin
        if (other_btn) begin
          state_nxt = WAIT_REL;
        end else if (!dir_btn) begin
          state_nxt = IDLE;
        end else if (cnt == ((state == HOLD) ? HOLD_LAST : REP_LAST)) begin
          req_up    = dir_up;
          req_down  = !dir_up;
          state_nxt = REPEAT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_REL: begin
        if (!btn_up && !btn_down && !btn_load)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state)
      cnt_nxt = '0;
  end

  // Outputs. Saturated requests are dropped, and the state keeps running so a held
  // button resumes once cur_temp moves off the limit.
  always_comb begin
    at_max       = (cur_temp == MAX_L);
    at_min       = (cur_temp == MIN_L);
    busy         = (state != IDLE);
    cmd_up_nxt   = req_up   && !at_max;
    cmd_down_nxt = req_down && !at_min;
    cmd_load_nxt = req_load;
  end

endmodule

// File: tb/tb_temp_range_ctrl.sv
module tb_temp_range_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_load = 1'b0;
  logic [3:0] cur_temp = 4'd5;
  logic       cmd_up, cmd_down, cmd_load, busy, at_max, at_min;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct packed {
    logic u, d, l, b;
    logic amax, amin;
  } exp_t;

  exp_t sb[$];

  temp_range_ctrl #(
    .W(4), .MAX_VAL(15), .MIN_VAL(0), .HOLD_CYC(4), .REPEAT_CYC(3)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
    .cur_temp(cur_temp),
    .cmd_up(cmd_up), .cmd_down(cmd_down), .cmd_load(cmd_load),
    .busy(busy), .at_max(at_max), .at_min(at_min)
  );

  always #5 clk = ~clk;

  // The task drives the inputs for one edge and queues the outputs expected after that edge.
  // It then waits past the edge, pops the expected values, and compares them.
  task automatic cyc(input logic r, input logic up, input logic dn, input logic ld,
                     input logic [3:0] t, input logic eu, input logic ed,
                     input logic el, input logic eb, input string tag);
    exp_t e, got;
    rst      = r;
    btn_up   = up;
    btn_down = dn;
    btn_load = ld;
    cur_temp = t;
    e.u = eu; e.d = ed; e.l = el; e.b = eb;
    e.amax = (t == 4'd15);
    e.amin = (t == 4'd0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    got = '{u: cmd_up, d: cmd_down, l: cmd_load, b: busy, amax: at_max, amin: at_min};
    n_cmp++;
    assert ({got.u, got.d, got.l, got.b} === {e.u, e.d, e.l, e.b})
      else begin
        n_err++;
        $error("FAIL %s: up/dn/ld/busy got %b%b%b%b exp %b%b%b%b", tag,
               got.u, got.d, got.l, got.b, e.u, e.d, e.l, e.b);
      end
    n_cmp++;
    assert ({got.amax, got.amin} === {e.amax, e.amin})
      else begin
        n_err++;
        $error("FAIL %s_lim: at_max/at_min got %b%b exp %b%b", tag,
               got.amax, got.amin, e.amax, e.amin);
      end
  endtask

  initial begin
    // 1. Reset while every button is held. Load is dropped as reset releases,
    //    and up+down held together lock the sequencer out with no pulse.
    cyc(1, 1, 1, 1, 5, 0, 0, 0, 0, "rst_all_btn");
    cyc(1, 1, 1, 1, 5, 0, 0, 0, 0, "rst_all_btn");
    cyc(0, 1, 1, 0, 5, 0, 0, 0, 1, "post_rst_wait");
    cyc(0, 1, 1, 0, 5, 0, 0, 0, 1, "post_rst_wait");
    cyc(0, 0, 0, 0, 5, 0, 0, 0, 0, "post_rst_idle");

    // 2. Single short press
    cyc(0, 1, 0, 0, 5, 1, 0, 0, 1, "tap_up");
    cyc(0, 0, 0, 0, 5, 0, 0, 0, 0, "tap_rel");
    cyc(0, 0, 0, 0, 5, 0, 0, 0, 0, "tap_idle");

    // 3. Hold for 12 cycles. Pulses are expected at t=1, 5, 8 and 11.
    for (int i = 0; i < 12; i++)
      cyc(0, 1, 0, 0, 5, (i == 0) || (i == 4) || (i == 7) || (i == 10), 0, 0, 1, "hold_up");
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 0, 0, 5, 0, 0, 0, 0, "hold_rel");

    // 4. Saturation at the upper limit. The register follows the first pulse to 15.
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 0, 0, (i == 0) ? 4'd14 : 4'd15, i == 0, 0, 0, 1, "sat_up");
    cyc(0, 0, 0, 0, 15, 0, 0, 0, 0, "sat_up_rel");
    //    Lower limit, then resume. At 0 the repeat slots 4 and 7 are suppressed;
    //    the value moves to 3, and the held button fires in slot 10.
    for (int i = 0; i < 12; i++)
      cyc(0, 0, 1, 0, (i == 0) ? 4'd1 : ((i >= 8) ? 4'd3 : 4'd0),
          0, (i == 0) || (i == 10), 0, 1, "sat_dn");
    cyc(0, 0, 0, 0, 2, 0, 0, 0, 0, "sat_dn_rel");

    // 5. Conflicts
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 1, 0, 5, 0, 0, 0, 1, "up_dn_both");
    cyc(0, 0, 1, 0, 5, 0, 0, 0, 1, "up_dn_one_left");
    cyc(0, 0, 0, 0, 5, 0, 0, 0, 0, "up_dn_rel");
    cyc(0, 1, 0, 1, 5, 0, 0, 1, 1, "load_up");
    cyc(0, 1, 0, 1, 5, 0, 0, 0, 1, "load_up_held");
    cyc(0, 1, 0, 0, 5, 0, 0, 0, 1, "load_up_only_up");
    cyc(0, 0, 0, 0, 5, 0, 0, 0, 0, "load_rel");

    // 6. Load asserted during a down repeat cancels further pulses
    for (int i = 0; i < 6; i++)
      cyc(0, 0, 1, 0, 8, 0, (i == 0) || (i == 4), 0, 1, "rep_dn");
    cyc(0, 0, 1, 1, 8, 0, 0, 0, 1, "rep_load");
    cyc(0, 0, 1, 1, 8, 0, 0, 0, 1, "rep_load");
    cyc(0, 0, 0, 0, 8, 0, 0, 0, 0, "rep_rel");
    //    Reset in the middle of HOLD drops the pending repeat
    cyc(0, 1, 0, 0, 8, 1, 0, 0, 1, "hold_pre_rst");
    cyc(0, 1, 0, 0, 8, 0, 0, 0, 1, "hold_pre_rst");
    cyc(0, 1, 0, 0, 8, 0, 0, 0, 1, "hold_pre_rst");
    cyc(1, 1, 0, 0, 8, 0, 0, 0, 0, "rst_mid_hold");
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 0, 0, 8, 0, 0, 0, 0, "post_rst_quiet");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
